// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one registered-read RAM between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for alternating conflict resolution; default is fixed data priority.
module mem_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              we_q;
  logic [1:0]        grant_q;
  logic              busy_q;
  logic              mem_we_q;
  logic              if_done_q;
  logic              d_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              win_data_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether the data port owned the most recent transaction.
  logic last_data_q;

  assign win_data_d = (if_req && d_req) ? !last_data_q : d_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_data_q <= 1'b0;
    end else if (state_q == S_IDLE && (if_req || d_req)) begin
      last_data_q <= win_data_d;
    end
  end
`else
  assign win_data_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || d_req) begin
            state_q  <= S_ACCESS;
            busy_q   <= 1'b1;
            grant_q  <= win_data_d ? 2'b10 : 2'b01;
            addr_q   <= win_data_d ? d_addr : if_addr;
            wdata_q  <= win_data_d ? d_wdata : '0;
            we_q     <= win_data_d && d_we;
            mem_we_q <= win_data_d && d_we;
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            state_q  <= S_DONE;
            d_done_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= LAT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          // Last latency cycle: RAM output is valid now, capture it for the owner.
          if (cnt_q == 3'd1) begin
            state_q <= S_DONE;
            if (grant_q[1]) begin
              d_rdata_q <= mem_rdata;
              d_done_q  <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          grant_q <= '0;
          addr_q  <= '0;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed and random stimulus.
module tb_mem_arbiter;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_done;
  logic [63:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic [63:0] d_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata;
  logic [1:0]  grant;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.DATA_W(64), .ADDR_W(64), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    return 64'h0F1E_2D3C_0000_0000 + 64'(i) * 64'h0101_0101;
  endfunction

  // Registered-read RAM with RL cycles of latency
  logic [63:0] ram [16];
  logic [63:0] rpipe [RL];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[6:3]] <= mem_wdata;
    rpipe[0] <= ram[mem_addr[6:3]];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  // Reference model: one transaction at a time, scheduled from the IDLE cycle it is sampled in
  logic [63:0] mmem [16];
  bit          model_ok = 0;
  bit          act = 0;
  int          s, len;
  bit          t_d, t_we, pd;
  logic [63:0] t_addr, t_wd, t_rv;
  logic [63:0] m_ifr = '0, m_dr = '0;
  bit          m_last_d = 0;
  logic        e_busy, e_we, e_ifd, e_dd;
  logic [1:0]  e_grant;
  logic [63:0] e_addr, e_wdata;

  always @(negedge clk) begin
    e_busy = 0; e_grant = 0; e_we = 0; e_ifd = 0; e_dd = 0; e_addr = 0; e_wdata = 0;
    if (act && cyc >= s + 1 && cyc <= s + len) begin
      e_busy  = 1;
      e_grant = t_d ? 2'b10 : 2'b01;
      e_addr  = t_addr;
      e_wdata = t_wd;
      e_we    = t_we && (cyc == s + 1);
      if (cyc == s + len) begin
        if (t_d) e_dd = 1; else e_ifd = 1;
        if (!t_we) begin
          if (t_d) m_dr = t_rv; else m_ifr = t_rv;
        end
      end
    end
    if (model_ok) begin
      chk("busy", busy, e_busy);
      chk("grant", grant, e_grant);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("if_done", if_done, e_ifd);
      chk("d_done", d_done, e_dd);
      chk("if_rdata", if_rdata, m_ifr);
      chk("d_rdata", d_rdata, m_dr);
    end
    if (reset) begin
      act = 0; m_ifr = '0; m_dr = '0; m_last_d = 0; model_ok = 1;
    end else if (model_ok && (!act || cyc > s + len) && (if_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (if_req && d_req) pd = !m_last_d; else pd = d_req;
`else
      pd = d_req;
`endif
      act    = 1;
      s      = cyc;
      t_d    = pd;
      t_we   = pd && d_we;
      t_addr = pd ? d_addr : if_addr;
      t_wd   = pd ? d_wdata : 64'd0;
      len    = t_we ? 2 : 2 + RL;
      if (t_we) mmem[t_addr[6:3]] = t_wd;
      else      t_rv = mmem[t_addr[6:3]];
      m_last_d = pd;
    end
  end

  // Event monitor; also plays the Moore requester that drops req on done
  int         we_pulses = 0, we_cyc = 0, busy_cnt = 0, d_done_cnt = 0;
  logic [63:0] we_addr = '0;
  logic [1:0] prev_grant = '0;
  logic [1:0] glog [$];
  bit         hold_mode = 0;

  always @(negedge clk) begin
    if (mem_we) begin we_pulses++; we_cyc = cyc; we_addr = mem_addr; end
    if (busy) busy_cnt++;
    if (d_done) d_done_cnt++;
    if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant);
    prev_grant = grant;
    if (!hold_mode) begin
      if (if_done) if_req = 1'b0;
      if (d_done)  d_req  = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input bit is_d, output int at);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (is_d ? d_done : if_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n, at, at_d, at_i, wp, bc, dc, gb;
    for (int i = 0; i < 16; i++) begin
      ram[i]  = init_word(i);
      mmem[i] = init_word(i);
    end
    ram[2]  = 64'h1122334455667788;
    mmem[2] = 64'h1122334455667788;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_ifrdata", if_rdata, 0);
    tick();

    // Single load
    n = cyc; wp = we_pulses;
    d_we = 0; d_addr = 64'h10; d_req = 1;
    wait_done(1, at);
    chk("load_lat", at - n, 5);
    chk("load_data", d_rdata, 64'h1122334455667788);
    tick();
    chk("load_no_we", we_pulses - wp, 0);

    // Single store, then read it back
    n = cyc; wp = we_pulses;
    d_we = 1; d_addr = 64'h20; d_wdata = 64'hDEADBEEF; d_req = 1;
    wait_done(1, at);
    chk("store_lat", at - n, 2);
    tick();
    chk("store_we_cnt", we_pulses - wp, 1);
    chk("store_we_cyc", we_cyc - n, 1);
    chk("store_we_addr", we_addr, 64'h20);
    d_we = 0; d_req = 1;
    wait_done(1, at);
    chk("store_readback", d_rdata, 64'hDEADBEEF);
    tick();

    // Reset held 2 cycles in the middle of a load
    dc = d_done_cnt;
    d_addr = 64'h10; d_req = 1;
    tick(); tick();
    reset = 1; d_req = 0;
    tick(); tick();
    reset = 0;
    @(negedge clk);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_drdata", d_rdata, 0);
    repeat (8) tick();
    chk("rst_mid_no_done", d_done_cnt - dc, 0);

    // Conflict right after reset: data wins, fetch follows after one IDLE cycle
    gb = glog.size();
    if_addr = 64'h0; d_addr = 64'h8; d_we = 0;
    if_req = 1; d_req = 1;
    wait_done(1, at_d);
    chk("conf_first_grant", glog[gb], 2'b10);
    chk("conf_if_unchanged", if_rdata, 0);
    chk("conf_d_data", d_rdata, init_word(1));
    wait_done(0, at_i);
    chk("conf_gap", at_i - at_d, 6);
    chk("conf_if_data", if_rdata, init_word(0));
    tick();
    chk("conf_second_grant", glog[gb+1], 2'b01);

    // Fetch latency with RL=3
    n = cyc; bc = busy_cnt;
    if_addr = 64'h4; if_req = 1;
    wait_done(0, at);
    chk("fetch_lat", at - n, 5);
    tick();
    chk("fetch_busy_cycles", busy_cnt - bc, 5);
    chk("fetch_data", if_rdata, init_word(0));

    // Both requests held across four transactions
    hold_mode = 1;
    gb = glog.size();
    if_addr = 64'h18; d_addr = 64'h28; d_we = 0;
    if_req = 1; d_req = 1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (glog.size() >= gb + 4) break;
    end
    if_req = 0; d_req = 0;
    chk("held_count_ok", glog.size() >= gb + 4, 1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("held_g0", glog[gb],   2'b10);
    chk("held_g1", glog[gb+1], 2'b01);
    chk("held_g2", glog[gb+2], 2'b10);
    chk("held_g3", glog[gb+3], 2'b01);
`else
    chk("held_g0", glog[gb],   2'b10);
    chk("held_g1", glog[gb+1], 2'b10);
    chk("held_g2", glog[gb+2], 2'b10);
    chk("held_g3", glog[gb+3], 2'b10);
`endif
    repeat (12) tick();
    hold_mode = 0;

    // Random traffic with stray input changes and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_addr = {$urandom, $urandom};
        if_req  = 1;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_addr  = {$urandom, $urandom};
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = {$urandom, $urandom};
        d_req   = 1;
      end
      if (busy && $urandom_range(0, 3) == 0) begin
        if_addr = {$urandom, $urandom};
        d_addr  = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        d_we    = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!if_req && !d_req && !busy) break;
    end
    tick();
    chk("drained", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
